decode_execute_unit: RTL and testbench

DECODE_EXECUTE_UNIT -- requirements
Module: decode_execute_unit

---
 rtl/dex_pkg.sv | 26 ++
 rtl/dex_alu.sv | 40 ++++
 rtl/decode_execute_unit.sv | 164 ++++++++++++++++
 tb/tb_decode_execute_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dex_pkg
// Description : Shared definitions for the decode/execute unit: opcode
//               enumeration and the base constants used by SLT and SEQ.
// Revision    : 1.0 - initial release
// ============================================================================
package dex_pkg;

    typedef enum logic [2:0] {
        OP_SUB  = 3'b000,
        OP_ADD  = 3'b001,
        OP_OR   = 3'b010,
        OP_AND  = 3'b011,
        OP_RORT = 3'b100,
        OP_ROLS = 3'b101,
        OP_SLT  = 3'b110,
        OP_SEQ  = 3'b111
    } op_e;

    // Offsets added to the 1-bit compare outcome of SLT / SEQ.
    localparam logic [3:0] SLT_BASE = 4'b1010;
    localparam logic [3:0] SEQ_BASE = 4'b1110;

endpackage
`default_nettype wire

// File: rtl/dex_alu.sv
`default_nettype none
// ============================================================================
// Module      : dex_alu
// Description : Purely combinational ALU for the execute stage.
//   op     in  3      opcode (see dex_pkg::op_e)
//   rs     in  WIDTH  first operand
//   rt     in  WIDTH  second operand
//   result out WIDTH  operation result
// Revision    : 1.0 - initial release
// ============================================================================
module dex_alu
    import dex_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_SUB:  result = rs - rt;
            OP_ADD:  result = rs + rt;
            OP_OR:   result = rs | rt;
            OP_AND:  result = rs & rt;
            // Rotate right: LSB wraps to the MSB.
            OP_RORT: result = {rt[0], rt[WIDTH-1:1]};
            // Rotate left: MSB wraps to bit 0.
            OP_ROLS: result = {rs[WIDTH-2:0], rs[WIDTH-1]};
            OP_SLT:  result = WIDTH'(SLT_BASE) + WIDTH'(rs < rt);
            OP_SEQ:  result = WIDTH'(SEQ_BASE) + WIDTH'(rs == rt);
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_unit
// Description : Two-stage (D/E) in-order pipeline with a small register file,
//               valid/ready handshakes on both sides and a host load port.
//   clk, rst                     clock, async active-high reset
//   in_valid/in_ready            instruction handshake
//   in_op, in_rs, in_rt, in_rd   instruction fields
//   out_valid/out_ready          result handshake (retirement)
//   out_rd, out_data             presented destination index and result
//   host_we/host_idx/host_data   host register-load port
//   retire_cnt                   16-bit wrapping count of retirements
// Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_unit
    import dex_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREG  = 4,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IDX_W-1:0] in_rs,
    input  logic [IDX_W-1:0] in_rt,
    input  logic [IDX_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_rd,
    output logic [WIDTH-1:0] out_data,
    input  logic             host_we,
    input  logic [IDX_W-1:0] host_idx,
    input  logic [WIDTH-1:0] host_data,
    output logic [15:0]      retire_cnt
);

    // D stage
    logic             r_d_valid;
    logic [2:0]       r_d_op;
    logic [IDX_W-1:0] r_d_rs;
    logic [IDX_W-1:0] r_d_rt;
    logic [IDX_W-1:0] r_d_rd;

    // E stage
    logic             r_e_valid;
    logic [IDX_W-1:0] r_e_rd;
    logic [WIDTH-1:0] r_e_data;

    logic [WIDTH-1:0] r_rf [NREG];
    logic [15:0]      r_retire_cnt;

    logic             w_e_adv;
    logic             w_d_adv;
    logic             w_accept;
    logic             w_retire;
    logic [WIDTH-1:0] w_rs_val;
    logic [WIDTH-1:0] w_rt_val;
    logic [WIDTH-1:0] w_alu_result;

    assign w_e_adv  = ~r_e_valid | out_ready;
    assign w_d_adv  = r_d_valid & w_e_adv;
    assign w_retire = r_e_valid & out_ready;
    // Gated by rst so in_ready drops the moment reset is asserted.
    assign in_ready = ~rst & (~r_d_valid | w_d_adv);
    assign w_accept = in_valid & in_ready;

    assign out_valid  = r_e_valid;
    assign out_rd     = r_e_rd;
    assign out_data   = r_e_data;
    assign retire_cnt = r_retire_cnt;

    // Operand fetch with forwarding: a retiring result is newest, then a
    // host write landing at the same edge, then the stored value.
    always_comb begin
        w_rs_val = r_rf[r_d_rs];
        if (host_we && (host_idx == r_d_rs)) begin
            w_rs_val = host_data;
        end
        if (w_retire && (r_e_rd == r_d_rs)) begin
            w_rs_val = r_e_data;
        end
    end

    always_comb begin
        w_rt_val = r_rf[r_d_rt];
        if (host_we && (host_idx == r_d_rt)) begin
            w_rt_val = host_data;
        end
        if (w_retire && (r_e_rd == r_d_rt)) begin
            w_rt_val = r_e_data;
        end
    end

    dex_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (r_d_op),
        .rs     (w_rs_val),
        .rt     (w_rt_val),
        .result (w_alu_result)
    );

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_d_op    <= '0;
            r_d_rs    <= '0;
            r_d_rt    <= '0;
            r_d_rd    <= '0;
            r_e_valid <= 1'b0;
            r_e_rd    <= '0;
            r_e_data  <= '0;
        end else begin
            if (w_accept) begin
                r_d_valid <= 1'b1;
                r_d_op    <= in_op;
                r_d_rs    <= in_rs;
                r_d_rt    <= in_rt;
                r_d_rd    <= in_rd;
            end else if (w_d_adv) begin
                r_d_valid <= 1'b0;
            end

            if (w_e_adv) begin
                r_e_valid <= r_d_valid;
                if (r_d_valid) begin
                    r_e_rd   <= r_d_rd;
                    r_e_data <= w_alu_result;
                end
            end
        end
    end

    // Register file: the retirement write is issued last so it overrides a
    // host write to the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (host_we) begin
                r_rf[host_idx] <= host_data;
            end
            if (w_retire) begin
                r_rf[r_e_rd] <= r_e_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_execute_unit
// Description : Scoreboard bench for decode_execute_unit (WIDTH=4, NREG=4).
//               Issued instructions push their expected (rd, data) into a
//               queue; a monitor pops and compares on every retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_execute_unit;
    import dex_pkg::*;

    localparam int c_limit = 200;

    typedef struct packed {
        logic [1:0] rd;
        logic [3:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_rs;
    logic [1:0]  in_rt;
    logic [1:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_rd;
    logic [3:0]  out_data;
    logic        host_we;
    logic [1:0]  host_idx;
    logic [3:0]  host_data;
    logic [15:0] retire_cnt;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    decode_execute_unit #(
        .WIDTH (4),
        .NREG  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .host_we    (host_we),
        .host_idx   (host_idx),
        .host_data  (host_data),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: inputs change just after posedge, so negedge sees the values
    // that the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got rd=%0d data=%0d, required no result", out_rd, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (out_rd !== e.rd || out_data !== e.data) begin
                    errors++;
                    $display("FAIL result got rd=%0d data=%0d, required rd=%0d data=%0d",
                             out_rd, out_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] idx, input logic [3:0] data);
        host_we   = 1'b1;
        host_idx  = idx;
        host_data = data;
        @(posedge clk);
        #1;
        host_we   = 1'b0;
    endtask

    task automatic offer(input logic [2:0] op, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [1:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
    endtask

    task automatic wait_accept();
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < c_limit);
        in_valid = 1'b0;
        check("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic [3:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
        offer(op, rs, rt, rd);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < c_limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", {31'd0, (sb_q.size() != 0) || out_valid}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        out_ready = 1'b1;
        host_we   = 1'b0;
        host_idx  = '0;
        host_data = '0;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_data", {28'd0, out_data}, 32'd0);
        check("rst_retire_cnt", {16'd0, retire_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Test 1: all-opcode sweep, r1=7 r2=5
        host_write(2'd1, 4'd7);
        host_write(2'd2, 4'd5);
        issue(OP_SUB,  2'd1, 2'd2, 2'd3, 4'd2);
        issue(OP_ADD,  2'd1, 2'd2, 2'd3, 4'd12);
        issue(OP_OR,   2'd1, 2'd2, 2'd3, 4'd7);
        issue(OP_AND,  2'd1, 2'd2, 2'd3, 4'd5);
        issue(OP_RORT, 2'd1, 2'd2, 2'd3, 4'd10);
        issue(OP_ROLS, 2'd1, 2'd2, 2'd3, 4'd14);
        issue(OP_SLT,  2'd1, 2'd2, 2'd3, 4'd10);
        issue(OP_SEQ,  2'd1, 2'd2, 2'd3, 4'd14);
        drain();
        check("retire_cnt_sweep", {16'd0, retire_cnt}, 32'd8);
        // SLT/SEQ true branches: 5<7, 5==5
        issue(OP_SLT,  2'd2, 2'd1, 2'd3, 4'd11);
        issue(OP_SEQ,  2'd2, 2'd2, 2'd3, 4'd15);
        drain();

        // Test 2: back-to-back dependent ADDs through the bypass
        host_write(2'd1, 4'd3);
        issue(OP_ADD, 2'd1, 2'd1, 2'd1, 4'd6);
        issue(OP_ADD, 2'd1, 2'd1, 2'd1, 4'd12);
        drain();
        issue(OP_OR, 2'd1, 2'd1, 2'd0, 4'd12);
        drain();

        // Test 3: backpressure with three instructions offered
        host_write(2'd0, 4'd4);
        host_write(2'd1, 4'd3);
        out_ready = 1'b0;
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4'd7);
        issue(OP_SUB, 2'd0, 2'd1, 2'd3, 4'd1);
        begin
            exp_t e;
            e.rd   = 2'd2;
            e.data = 4'd0;
            sb_q.push_back(e);
        end
        offer(OP_AND, 2'd0, 2'd1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {28'd0, out_data}, 32'd7);
            check("bp_out_rd", {30'd0, out_rd}, 32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Test 4: host write and retirement to r2 at the same edge
        host_write(2'd0, 4'd4);
        begin
            exp_t e;
            e.rd   = 2'd2;
            e.data = 4'd4;
            sb_q.push_back(e);
        end
        offer(OP_OR, 2'd0, 2'd0, 2'd2);
        wait_accept();
        @(posedge clk);
        #1;
        host_we   = 1'b1;
        host_idx  = 2'd2;
        host_data = 4'd9;
        @(posedge clk);
        #1;
        host_we   = 1'b0;
        drain();
        issue(OP_OR, 2'd2, 2'd2, 2'd3, 4'd4);
        drain();

        // Test 5: reset with D and E both holding instructions
        host_write(2'd0, 4'd5);
        host_write(2'd1, 4'd6);
        out_ready = 1'b0;
        offer(OP_ADD, 2'd0, 2'd1, 2'd2);
        wait_accept();
        offer(OP_SUB, 2'd0, 2'd1, 2'd3);
        wait_accept();
        check("mid_out_valid_before", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_retire_cnt", {16'd0, retire_cnt}, 32'd0);
        check("mid_rst_out_data", {28'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_post_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            issue(OP_OR, 2'(i), 2'(i), 2'(i), 4'd0);
        end
        drain();
        check("mid_retire_cnt", {16'd0, retire_cnt}, 32'd4);

        // Test 6: retire_cnt wrap
        reset_pulse();
        for (int i = 0; i < 65535; i++) begin
            issue(OP_SEQ, 2'd0, 2'd0, 2'd3, 4'd15);
        end
        drain();
        check("cnt_max", {16'd0, retire_cnt}, 32'h0000_FFFF);
        issue(OP_SEQ, 2'd0, 2'd0, 2'd3, 4'd15);
        drain();
        check("cnt_wrap", {16'd0, retire_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
